// File: rtl/mem_io_bridge_pkg.sv
// rtl/mem_io_bridge_pkg.sv - address map and read-region encodings for the memory/IO bridge
package mem_io_bridge_pkg;

  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;
  localparam logic [1:0]  IO_REGION    = 2'b11;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_RAM,
    RG_UART,
    RG_CNT0,
    RG_CNT1,
    RG_CNT2,
    RG_CNT3
  } region_e;

  // Source that will drive mem_din on the cycle after a read of address a.
  function automatic region_e decode_read(input logic [17:0] a);
    region_e r;
    r = RG_NONE;
    if (a[17:16] != IO_REGION) begin
      r = RG_RAM;
    end else if (a == IO_UART_ADDR) begin
      r = RG_UART;
    end else if (a[17:2] == IO_CNT_ADDR[17:2]) begin
      case (a[1:0])
        2'd0:    r = RG_CNT0;
        2'd1:    r = RG_CNT1;
        2'd2:    r = RG_CNT2;
        default: r = RG_CNT3;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// rtl/io_byte_fifo.sv - 8-bit byte FIFO with push/pop, full/empty and free-slot count
module io_byte_fifo #(
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [7:0]           push_data,
  input  logic                 pop,
  output logic [7:0]           head,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   free
);

  localparam logic [DEPTH_LOG:0] DEPTH_W = (DEPTH_LOG + 1)'(1 << DEPTH_LOG);

  logic [7:0]           mem [1 << DEPTH_LOG];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 pop_ok;
  logic                 push_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_W);
  assign free    = DEPTH_W - count;
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - decodes the cpu memory bus into external RAM, UART byte port and cycle counter
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        prog_end
);

  localparam logic [TX_DEPTH_LOG:0] MARGIN_W = (TX_DEPTH_LOG + 1)'(FULL_MARGIN);

  logic [17:0]           a;
  logic                  unused_hi_addr;
  logic                  is_ram;
  logic                  bus_wr;
  logic                  bus_rd;
  region_e               rd_region;
  region_e               region_q;
  logic                  stall_q;
  logic [7:0]            hold_q;
  logic [7:0]            rx_byte_q;
  logic [31:0]           counter;
  logic [31:0]           snapshot;

  logic                  tx_push;
  logic [7:0]            tx_push_data;
  logic                  tx_pop;
  logic                  tx_empty;
  logic [TX_DEPTH_LOG:0] tx_free;
  logic                  unused_tx_full;
  logic                  rx_pop;
  logic [7:0]            rx_head;
  logic                  rx_empty;
  logic                  unused_rx_full;
  logic [RX_DEPTH_LOG:0] unused_rx_free;

  assign a              = mem_a[17:0];
  assign unused_hi_addr = ^mem_a[31:18];
  assign is_ram         = (a[17:16] != IO_REGION);
  assign bus_wr         = rdy_in & mem_wr;
  assign bus_rd         = rdy_in & ~mem_wr;
  assign rd_region      = decode_read(a);

  assign ram_a     = mem_a[16:0];
  assign ram_we    = mem_wr & rdy_in & is_ram;
  assign ram_wdata = mem_dout;

  // A zero byte to the UART port is ignored; the stop port pushes a zero as end marker.
  assign tx_push      = bus_wr & (((a == IO_UART_ADDR) & (mem_dout != 8'h00)) | (a == IO_CNT_ADDR));
  assign tx_push_data = (a == IO_CNT_ADDR) ? 8'h00 : mem_dout;
  assign tx_valid     = ~tx_empty;
  assign tx_pop       = tx_valid & tx_ready;
  assign rx_pop       = bus_rd & (a == IO_UART_ADDR) & ~rx_empty;

  io_byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (unused_tx_full),
    .empty     (tx_empty),
    .free      (tx_free)
  );

  io_byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (unused_rx_full),
    .empty     (rx_empty),
    .free      (unused_rx_free)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      region_q       <= RG_NONE;
      stall_q        <= 1'b0;
      hold_q         <= 8'h00;
      rx_byte_q      <= 8'h00;
      counter        <= 32'd0;
      snapshot       <= 32'd0;
      prog_end       <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      stall_q        <= ~rdy_in;
      hold_q         <= mem_din;
      io_buffer_full <= (tx_free < MARGIN_W);
      if (rdy_in) begin
        counter  <= counter + 32'd1;
        region_q <= mem_wr ? RG_NONE : rd_region;
        if (bus_rd && rd_region == RG_UART) begin
          rx_byte_q <= rx_empty ? 8'h00 : rx_head;
        end
        if (bus_rd && rd_region == RG_CNT0) begin
          snapshot <= counter;
        end
        if (bus_wr && a == IO_CNT_ADDR) begin
          prog_end <= 1'b1;
        end
      end
    end
  end

  // While paused the RAM keeps reading whatever ram_a shows, so replay the last byte instead.
  always_comb begin
    mem_din = 8'h00;
    if (stall_q) begin
      mem_din = hold_q;
    end else begin
      case (region_q)
        RG_RAM:  mem_din = ram_rdata;
        RG_UART: mem_din = rx_byte_q;
        RG_CNT0: mem_din = snapshot[7:0];
        RG_CNT1: mem_din = snapshot[15:8];
        RG_CNT2: mem_din = snapshot[23:16];
        RG_CNT3: mem_din = snapshot[31:24];
        default: mem_din = 8'h00;
      endcase
    end
  end

endmodule
